// File: rtl/instruction_decoder.sv
// instruction_decoder: consumer end of the program-sequencer interface.
// Decodes the 8-bit program-memory word into sequencer jump controls and
// ALU enables. It also holds the zero flag, a sticky illegal-opcode flag and,
// when INSTR_DECODER_DJNZ_EN is defined, a DJNZ loop counter with LOOP/DJNZ.
//
// Interface timing: there is no valid/ready handshake. Every cycle the word
// on pm_data is the instruction at pc, and the decode outputs are its
// zero-latency response. The internal dec_valid register, ANDed with
// sync_reset_n, qualifies the outputs. While they are unqualified, jmp,
// jmp_nz, alu_en and alu_ctrl are 0 and dont_jmp is 1, so the sequencer
// simply steps.

module instruction_decoder #(
  parameter int LOOP_W = 4
) (
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic       alu_en,
  output logic [6:0] alu_ctrl,
  output logic       zero_flag,
  output logic       illegal_op
);

  logic dec_valid;
  logic active;
  logic is_alu;
  logic is_jmp;
  logic is_jnz;
  logic is_rsv;
  logic djnz_go;

  // Reset forces the outputs inactive immediately, not only after the edge.
  assign active = dec_valid & sync_reset_n;

  assign is_alu = ~pm_data[7];
  assign is_jmp = (pm_data[7:4] == 4'h8);
  assign is_jnz = (pm_data[7:4] == 4'h9);
  assign is_rsv = (pm_data[7:5] == 3'b111);

`ifdef INSTR_DECODER_DJNZ_EN
  logic [LOOP_W-1:0] loop_cnt;
  logic              is_loop;
  logic              is_djnz;

  assign is_loop = (pm_data[7:4] == 4'hA);
  assign is_djnz = (pm_data[7:4] == 4'hB);
  assign djnz_go = active & is_djnz;

  // Loop counter: LOOP loads the immediate; DJNZ decrements and wraps modulo 2^LOOP_W.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      loop_cnt <= '0;
    end else if (active && is_loop) begin
      loop_cnt <= LOOP_W'(pm_data[3:0]);
    end else if (djnz_go) begin
      loop_cnt <= loop_cnt - LOOP_W'(1);
    end
  end
`else
  logic unused_loop_w;

  // Without the loop feature, 1010/1011 fall through as NOP.
  assign djnz_go       = 1'b0;
  assign unused_loop_w = (LOOP_W > 0);
`endif

  // Decode outputs: combinational from pm_data and the registered state.
  always_comb begin
    jmp      = active & is_jmp;
    jmp_nz   = (active & is_jnz) | djnz_go;
    jmp_addr = pm_data[3:0];
    alu_en   = active & is_alu;
    alu_ctrl = (active & is_alu) ? pm_data[6:0] : 7'h00;
    dont_jmp = 1'b1;
    if (active && is_jnz) begin
      dont_jmp = zero_flag;
    end
`ifdef INSTR_DECODER_DJNZ_EN
    if (djnz_go) begin
      dont_jmp = (loop_cnt == LOOP_W'(1));
    end
`endif
  end

  // Status registers: the decode qualifier, the zero flag (updated only by
  // ALU words, so a JNZ in the next cycle sees it) and the sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      dec_valid  <= 1'b0;
      zero_flag  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      dec_valid <= 1'b1;
      if (alu_en) begin
        zero_flag <= alu_zero;
      end
      if (active && is_rsv) begin
        illegal_op <= 1'b1;
      end
    end
  end

endmodule
